fact_ctrl: RTL and testbench

- Moore FSM that sequences the factorial datapath: the up-counter (load/increment) and the product register/multiplier.
- Accepts a start request with operand n.
- Drives counter load/enable and product init/update until the counter exceeds n.
- Reports done or error, the latter on range or overflow.
- Sits between the top-level request interface and the counter + multiplier datapath. The datapath itself is outside this block.

---
 rtl/fact_pkg.sv | 69 ++++++
 rtl/fact_ctrl.sv | 84 ++++++++
 tb/tb_fact_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/fact_pkg.sv
// rtl/fact_pkg.sv - shared constants, state encoding and output decode for the factorial sequencer
//   FACT_SIZE / FACT_MAX_N : default operand width and largest accepted operand
//   ST_*                   : 3-bit state encoding shared with the datapath and top level
//   fact_out_s             : bundle of the controller's datapath/status outputs
//   fact_decode()          : Moore output decode for one state
package fact_pkg;

  localparam int FACT_SIZE  = 8;
  localparam int FACT_MAX_N = 12;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_INIT  = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_MULT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_ERR   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_INIT  = ST_INIT,
    S_CHECK = ST_CHECK,
    S_MULT  = ST_MULT,
    S_DONE  = ST_DONE,
    S_ERR   = ST_ERR
  } fact_state_e;

  typedef struct packed {
    logic cnt_en;
    logic cnt_load;
    logic prod_init;
    logic prod_en;
    logic busy;
    logic done;
    logic err;
  } fact_out_s;

  // Outputs owned by each state; anything not listed stays low.
  function automatic fact_out_s fact_decode(input fact_state_e s);
    fact_out_s o;
    o = '0;
    case (s)
      S_INIT: begin
        o.cnt_en    = 1'b1;
        o.cnt_load  = 1'b1;
        o.prod_init = 1'b1;
        o.busy      = 1'b1;
      end
      S_CHECK: begin
        o.busy = 1'b1;
      end
      S_MULT: begin
        o.cnt_en  = 1'b1;
        o.prod_en = 1'b1;
        o.busy    = 1'b1;
      end
      S_DONE: begin
        o.done = 1'b1;
      end
      S_ERR: begin
        o.err = 1'b1;
      end
      default: begin
        o = '0;
      end
    endcase
    return o;
  endfunction

endpackage

// File: rtl/fact_ctrl.sv
// rtl/fact_ctrl.sv - Moore sequencer for the factorial counter + multiplier datapath
//   clk_, rst_n_  : clock (rising edge), asynchronous active-low reset
//   go_, n_       : start request and operand, sampled only while idle
//   cnt_q_        : counter value from the datapath
//   prod_ovf_     : datapath flag, the multiply in flight this cycle overflows
//   cnt_en_, cnt_load_, cnt_d_ : counter enable, load select, load value (always 1)
//   prod_init_, prod_en_       : product := 1, product := product * cnt_q_
//   busy_, done_, err_         : in flight, result valid pulse, rejected/aborted pulse
module fact_ctrl
  import fact_pkg::*;
#(
  parameter int SIZE_  = FACT_SIZE,
  parameter int MAX_N_ = FACT_MAX_N
) (
  input  logic             clk_,
  input  logic             rst_n_,
  input  logic             go_,
  input  logic [SIZE_-1:0] n_,
  input  logic [SIZE_-1:0] cnt_q_,
  input  logic             prod_ovf_,
  output logic             cnt_en_,
  output logic             cnt_load_,
  output logic [SIZE_-1:0] cnt_d_,
  output logic             prod_init_,
  output logic             prod_en_,
  output logic             busy_,
  output logic             done_,
  output logic             err_
);

  localparam logic [SIZE_-1:0] MAX_N_V = SIZE_'(MAX_N_);

  fact_state_e      state_q, state_d;
  logic [SIZE_-1:0] n_reg_q, n_reg_d;
  fact_out_s        out_q, out_d;

  always_comb begin
    state_d = state_q;
    n_reg_d = n_reg_q;
    case (state_q)
      S_IDLE: begin
        if (go_) begin
          n_reg_d = n_;
          state_d = (n_ > MAX_N_V) ? S_ERR : S_INIT;
        end
      end
      S_INIT:  state_d = S_CHECK;
      // Counter starts at 1 and walks up; it has multiplied in 1..n once it passes n.
      S_CHECK: state_d = (cnt_q_ > n_reg_q) ? S_DONE : S_MULT;
      S_MULT:  state_d = prod_ovf_ ? S_ERR : S_CHECK;
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up
  // with state_q and never see a combinational path from the inputs.
  always_comb begin
    out_d = fact_decode(state_d);
  end

  always_ff @(posedge clk_ or negedge rst_n_) begin
    if (!rst_n_) begin
      state_q <= S_IDLE;
      n_reg_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      n_reg_q <= n_reg_d;
      out_q   <= out_d;
    end
  end

  assign cnt_en_    = out_q.cnt_en;
  assign cnt_load_  = out_q.cnt_load;
  assign prod_init_ = out_q.prod_init;
  assign prod_en_   = out_q.prod_en;
  assign busy_      = out_q.busy;
  assign done_      = out_q.done;
  assign err_       = out_q.err;
  assign cnt_d_     = SIZE_'(1);

endmodule

// File: tb/tb_fact_ctrl.sv
// tb/tb_fact_ctrl.sv - randomized self-checking bench for fact_ctrl with a counter/product datapath model
module tb_fact_ctrl;
  import fact_pkg::*;

  localparam int SIZE  = 8;
  localparam int MAX_N = 12;

  logic            clk_ = 1'b0;
  logic            rst_n_ = 1'b0;
  logic            go_ = 1'b0;
  logic [SIZE-1:0] n_ = '0;
  logic [SIZE-1:0] cnt_q_ = '0;
  logic            prod_ovf_ = 1'b0;
  logic            cnt_en_, cnt_load_, prod_init_, prod_en_, busy_, done_, err_;
  logic [SIZE-1:0] cnt_d_;
  logic [31:0]     prod = 32'd0;

  int tests_run = 0;
  int tests_failed = 0;

  fact_ctrl #(.SIZE_(SIZE), .MAX_N_(MAX_N)) dut (
    .clk_(clk_), .rst_n_(rst_n_), .go_(go_), .n_(n_), .cnt_q_(cnt_q_),
    .prod_ovf_(prod_ovf_), .cnt_en_(cnt_en_), .cnt_load_(cnt_load_),
    .cnt_d_(cnt_d_), .prod_init_(prod_init_), .prod_en_(prod_en_),
    .busy_(busy_), .done_(done_), .err_(err_)
  );

  always #5 clk_ = ~clk_;

  // Behavioural datapath: up-counter and product register.
  always @(posedge clk_) begin
    if (cnt_en_) cnt_q_ <= cnt_load_ ? cnt_d_ : cnt_q_ + 8'd1;
    if (prod_init_) prod <= 32'd1;
    else if (prod_en_) prod <= prod * 32'(cnt_q_);
  end

  task automatic chk(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int factorial(input int n);
    int r = 1;
    for (int i = 2; i <= n; i++) r = r * i;
    return r;
  endfunction

  function automatic int outs_vec();
    return int'({cnt_en_, cnt_load_, prod_init_, prod_en_, busy_, done_, err_});
  endfunction

  // One request; ovf_at = index of the MULT cycle to flag as overflowing (0 = never).
  task automatic run_req(input int n, input int ovf_at, input string tag);
    int  k, mults, busy_cnt, done_k, err_k;
    int  exp_done, exp_err, exp_mults, exp_busy;
    bit  fin;
    @(negedge clk_);
    go_ = 1'b1;
    n_  = SIZE'(n);
    @(posedge clk_);
    @(negedge clk_);
    go_ = 1'b0;
    n_  = SIZE'($urandom);
    k = 1; mults = 0; busy_cnt = 0; done_k = -1; err_k = -1; fin = 1'b0;
    if (n <= MAX_N)
      chk({tag, "_init"}, int'({cnt_en_, cnt_load_, prod_init_, prod_en_}), 4'b1110);
    else
      chk({tag, "_range"}, int'({err_, cnt_en_, prod_init_, prod_en_}), 4'b1000);
    while (!fin && k < 100) begin
      if (prod_en_) begin
        mults++;
        chk({tag, "_cntq"}, int'(cnt_q_), mults);
        chk({tag, "_excl"}, int'(prod_init_), 0);
        if (mults == ovf_at) prod_ovf_ = 1'b1;
      end
      busy_cnt += int'(busy_);
      if (done_) begin done_k = k; fin = 1'b1; end
      if (err_)  begin err_k = k;  fin = 1'b1; end
      if (!fin) begin
        @(negedge clk_);
        prod_ovf_ = 1'b0;
        k++;
      end
    end
    chk({tag, "_timeout"}, int'(fin), 1);
    if (n > MAX_N) begin
      exp_done = -1; exp_err = 1; exp_mults = 0; exp_busy = 0;
    end else if (ovf_at >= 1 && ovf_at <= n) begin
      exp_done = -1; exp_err = 2 * ovf_at + 2; exp_mults = ovf_at; exp_busy = 1 + 2 * ovf_at;
    end else begin
      exp_done = 3 + 2 * n; exp_err = -1; exp_mults = n; exp_busy = 2 + 2 * n;
      chk({tag, "_prod"}, int'(prod), factorial(n));
    end
    chk({tag, "_done_cyc"}, done_k, exp_done);
    chk({tag, "_err_cyc"}, err_k, exp_err);
    chk({tag, "_mults"}, mults, exp_mults);
    chk({tag, "_busy"}, busy_cnt, exp_busy);
    @(negedge clk_);
    chk({tag, "_idle"}, int'({busy_, done_, err_, cnt_en_, prod_en_}), 0);
  endtask

  initial begin
    int done_cnt, init_cnt, first_done, second_init, noise;
    // Reset state
    #1;
    chk("rst_outs", outs_vec(), 0);
    chk("rst_cnt_d", int'(cnt_d_), 1);
    repeat (2) @(negedge clk_);
    rst_n_ = 1'b1;
    @(negedge clk_);
    chk("idle_outs", outs_vec(), 0);

    // Directed cases
    run_req(0, 0, "n0");
    run_req(5, 0, "n5");
    run_req(13, 0, "n13");
    run_req(10, 4, "ovf");
    run_req(3, 0, "after_ovf");
    run_req(12, 0, "nmax");

    // go_ held continuously with n=2
    @(negedge clk_);
    go_ = 1'b1;
    n_  = SIZE'(2);
    @(posedge clk_);
    done_cnt = 0; init_cnt = 0; first_done = -1; second_init = -1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk_);
      if (k == 10) go_ = 1'b0;
      if (done_) begin
        done_cnt++;
        if (first_done < 0) first_done = k;
      end
      if (cnt_load_) begin
        init_cnt++;
        if (init_cnt == 2) second_init = k;
      end
    end
    chk("held_done_cyc", first_done, 7);
    chk("held_reinit_cyc", second_init, 9);
    chk("held_inits", init_cnt, 2);
    chk("held_dones", done_cnt, 2);
    @(negedge clk_);

    // Asynchronous reset mid-MULT
    @(negedge clk_);
    go_ = 1'b1;
    n_  = SIZE'(6);
    @(posedge clk_);
    @(negedge clk_);
    go_ = 1'b0;
    repeat (4) @(negedge clk_);
    chk("rst_mid_mult", int'(prod_en_), 1);
    #2 rst_n_ = 1'b0;
    #1;
    chk("rst_async_outs", outs_vec(), 0);
    chk("rst_async_state", int'(dut.state_q), int'(ST_IDLE));
    repeat (2) @(negedge clk_);
    rst_n_ = 1'b1;
    noise = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_);
      noise += int'(done_) + int'(err_) + int'(busy_);
    end
    chk("rst_quiet", noise, 0);

    // Randomized requests
    for (int i = 0; i < 14; i++) begin
      int rn, ro;
      rn = int'($urandom_range(0, 15));
      ro = 0;
      if (rn >= 1 && rn <= MAX_N && $urandom_range(0, 2) == 0) ro = int'($urandom_range(1, rn));
      repeat ($urandom_range(0, 3)) @(negedge clk_);
      run_req(rn, ro, $sformatf("rnd%0d_n%0d_o%0d", i, rn, ro));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
